// File: rtl/borrow_select_subtractor_seq.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit borrow-select slice per clock.
// Optional signed-overflow flag output enabled by defining SUB_OVF_FLAG_EN.
module borrow_select_subtractor_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [KW-1:0]    k_q, k_d;
`ifdef SUB_OVF_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    logic [3:0] a_nib [NSLICE];
    logic [3:0] b_nib [NSLICE];
    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [4:0] d0;
    logic [4:0] d1;
    logic [4:0] sel;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_nib
            assign a_nib[gi] = a_q[4*gi +: 4];
            assign b_nib[gi] = b_q[4*gi +: 4];
        end
    endgenerate

    // Both borrow-in candidates are formed in parallel; bit 4 is the slice borrow.
    assign slice_a = a_nib[k_q];
    assign slice_b = b_nib[k_q];
    assign d0      = {1'b0, slice_a} - {1'b0, slice_b};
    assign d1      = d0 - 5'd1;
    assign sel     = borrow_q ? d1 : d0;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        k_d      = k_q;
`ifdef SUB_OVF_FLAG_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    k_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d[4*k_q +: 4] = sel[3:0];
                borrow_d           = sel[4];
                k_d                = k_q + 1'b1;
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    bout_d  = sel[4];
                    state_d = DONE;
`ifdef SUB_OVF_FLAG_EN
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            k_q      <= '0;
`ifdef SUB_OVF_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            k_q      <= k_d;
`ifdef SUB_OVF_FLAG_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SUB_OVF_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_borrow_select_subtractor_seq.sv
// Scoreboard bench for borrow_select_subtractor_seq (WIDTH=16): stimulus pushes
// hand-computed results, a negedge monitor pops and compares on each output handshake.
module tb_borrow_select_subtractor_seq;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_FLAG_EN
    logic             ovf;
`endif

    borrow_select_subtractor_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
        int               acc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   seen   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: latency on first valid cycle, result compare on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - exp_q[0].acc), 32'(NSLICE));
                    seen = 1;
                end
                if (out_ready) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("diff", 32'(diff), 32'(e.d));
                    chk("bout", 32'(bout), 32'(e.bo));
`ifdef SUB_OVF_FLAG_EN
                    chk("ovf", 32'(ovf), 32'(e.ov));
`endif
                    seen = 0;
                end
            end
        end
    end

    // Called and returns at posedge+1; acc is the cycle number right after the accept edge.
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin,
                         input logic [WIDTH-1:0] ed, input logic eb, input logic eo,
                         input bit push, output int acc);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb;
        bin      = tbin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc      = cyc;
        $display("issue a=%h b=%h bin=%0d expect diff=%h bout=%0d ovf=%0d", ta, tb, tbin, ed, eb, eo);
        if (push) begin
            e.d = ed; e.bo = eb; e.ov = eo; e.acc = acc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc1, acc2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_FLAG_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1, acc1);
        issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1, acc1);
        issue(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1, acc1);
        issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1, acc1);
        issue(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1, acc1);
        issue(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1, acc1);
        drain();

        // Backpressure: DONE held for 10 cycles while a new request is offered.
        out_ready = 1'b0;
        issue(16'h4321, 16'h1111, 1'b0, 16'h3210, 1'b0, 1'b0, 1, acc1);
        for (int n = 0; n < 50 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 16'hFFFF;
            b        = 16'h0000;
            @(posedge clk); #1;
            chk("bp_diff", 32'(diff), 32'h3210);
            chk("bp_bout", 32'(bout), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Reset during slice 2 of RUN; the operation must vanish.
        issue(16'hAAAA, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 0, acc1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        issue(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1, acc1);
        drain();

        // Back-to-back with out_ready tied high.
        issue(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1, acc1);
        issue(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1, acc2);
        chk("b2b_spacing", 32'(acc2 - acc1), 32'(NSLICE + 2));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/borrow_select_subtractor_seq.md
# borrow_select_subtractor_seq

Nibble-serial unsigned subtractor that computes `diff = a - b - bin` over a WIDTH-bit operand pair, one 4-bit slice per clock. Each slice is resolved borrow-select style: both borrow-in-0 and borrow-in-1 slice results are formed in parallel, and the stored borrow from the previous slice selects between them. It is the subtract-side counterpart of the team's 4-bit carry-select adder and sits behind a valid/ready handshake in the datapath, trading latency for area on wide operands.

## Interface
- `WIDTH`, 16: operand width in bits; multiple of 4, minimum 4. `NSLICE = WIDTH/4`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands presented.
- `in_ready` output 1: block idle and able to accept.
- `a` input WIDTH: minuend, unsigned.
- `b` input WIDTH: subtrahend, unsigned.
- `bin` input 1: borrow-in.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout` output 1: final borrow; 1 when `a < b + bin`, unsigned.
- `ovf` output 1: signed overflow. Present only with `SUB_OVF_FLAG_EN`.

## Operation
- States are IDLE, RUN and DONE.
- IDLE: `in_ready=1`. On `in_valid && in_ready`, capture `a`, `b` and `bin`, set the stored borrow to `bin`, set the slice index to 0, and go to RUN. Operands are sampled only at this edge.
- RUN: `in_ready=0`. Each cycle, process slice `k` (bits `4k+3:4k`):
  - d0 and bo0 = `a_k - b_k - 0`.
  - d1 and bo1 = `a_k - b_k - 1`.
  - Select on the stored borrow. Write the nibble into `diff[4k+3:4k]`, update the stored borrow, and increment `k`.
  - After slice `NSLICE-1`, load `bout` from the final borrow and go to DONE.
- DONE: `out_valid=1`. `diff`, `bout` and `ovf` are held stable until `out_valid && out_ready`, then the block returns to IDLE.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- Width rules:
  - Each slice subtraction is evaluated at 5 bits; bit 4 is the slice borrow.
  - The result wraps modulo 2^WIDTH.
  - Final borrow out equals the NOT of the carry of `a + ~b + ~bin`.
- `diff` holds the last result across IDLE. It is only overwritten slice-by-slice during the next RUN.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `diff=0`, `bout=0`, `ovf=0`. State is IDLE and slice index is 0.
- Latency: with acceptance at edge E0, `out_valid` rises after edge E_NSLICE (4 cycles for WIDTH=16).
- Throughput: one operation per `NSLICE+2` cycles minimum. In the earliest case:
  - `out_ready` is high on the first DONE cycle.
  - IDLE is re-entered on the following edge.
  - `in_ready` is asserted in the cycle after the result handshake, never in the same cycle.
- Backpressure: DONE persists indefinitely while `out_ready=0`, and outputs do not change.
- Reset mid-operation: asserting `rst_n` low at any time immediately forces the reset values. The in-flight operation is discarded, and no partial `out_valid` pulse occurs.
- WIDTH=4: RUN lasts exactly one cycle.

## Configuration
- `SUB_OVF_FLAG_EN`, defined:
  - `ovf` port exists.
  - `ovf` is registered on entry to DONE as `(a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])`, treating the operands as two's complement. `bin` is included in `diff`.
  - `ovf` is held with `diff`.
- `SUB_OVF_FLAG_EN`, undefined: no `ovf` port and no related logic. All other behaviour is identical.

## Test plan
- Basic subtract, WIDTH=16: a=0x1234, b=0x0234, bin=0 -> after 4 cycles `diff=0x1000`, `bout=0`, `out_valid=1`.
- Full-width borrow ripple: a=0x0000, b=0x0001, bin=0 -> `diff=0xFFFF`, `bout=1`. With bin=1 on a=0x0005, b=0x0005 -> `diff=0xFFFF`, `bout=1`.
- Signed overflow with `SUB_OVF_FLAG_EN`: a=0x8000, b=0x0001 -> `diff=0x7FFF`, `bout=0`, `ovf=1`. With a=0x0003, b=0x0001 -> `ovf=0`.
- Backpressure:
  - Hold `out_ready=0` for 10 cycles in DONE -> `diff`, `bout` and `out_valid` stay constant and `in_ready` stays 0.
  - A new `in_valid` during this time is ignored.
  - Raise `out_ready` -> IDLE next cycle.
- Reset mid-operation: assert `rst_n=0` during RUN slice 2 -> `out_valid=0`, `diff=0`, `in_ready=1` immediately. After release, a=0x00FF, b=0x000F completes as `diff=0x00F0`.
- Back-to-back: 0x0010-0x0001 then 0xFFFF-0xFFFF with `out_ready` tied high -> results `0x000F` and `0x0000`, separated by exactly `NSLICE+2` cycles, with no dropped or duplicated `out_valid`.
